conv3x3_stream: RTL

Parametrised streaming 3x3 convolution engine, the successor of the fixed 28x28 nine-multiplier Conv block.
- Takes a raster-order pixel stream over a valid/ready handshake and buffers two image rows in internal line buffers.
- Emits one "valid" (unpadded) convolution result per accepted window over a valid/ready output handshake.
- Image size, data width, coefficient width and output scaling are parameters.
- Sits between the input pixel source and the result RAM / next layer.

---
 rtl/conv3x3_stream.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 valid-window convolution with two line buffers.
// Optional ROUND_EN macro selects round-half-up before the output shift.
module conv3x3_stream #(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int SHIFT  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [9*COEF_W-1:0]   kernel,
   input  logic [DATA_W-1:0]     in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done
);

   localparam int ACC_W = DATA_W + COEF_W + 5;
   localparam int PW    = DATA_W + COEF_W + 1;
   localparam int CW    = $clog2(IMG_W);
   localparam int RW    = $clog2(IMG_H);
   localparam int NOUT  = (IMG_W - 2) * (IMG_H - 2);
   localparam int OW    = $clog2(NOUT + 1);

   localparam logic [CW-1:0] CLAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] RLAST = RW'(IMG_H - 1);
   localparam logic [OW-1:0] OLAST = OW'(NOUT - 1);
   localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((2 ** DATA_W) - 1);
`ifdef ROUND_EN
   localparam logic signed [ACC_W-1:0] RND = ACC_W'((2 ** SHIFT) / 2);
`else
   localparam logic signed [ACC_W-1:0] RND = '0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

   state_t state, nstate;

   logic                     stall, accept, last_px, last_out;
   logic [CW-1:0]            c;
   logic [RW-1:0]            r;
   logic [OW-1:0]            ocnt;
   logic signed [COEF_W-1:0] k      [9];
   logic [DATA_W-1:0]        lb0    [IMG_W];
   logic [DATA_W-1:0]        lb1    [IMG_W];
   logic [DATA_W-1:0]        win    [3][2];
   logic [DATA_W-1:0]        col    [3];
   logic [DATA_W-1:0]        px     [9];
   logic signed [PW-1:0]     prod   [9];
   logic signed [PW-1:0]     prod_q [9];
   logic                     v1;
   logic signed [ACC_W-1:0]  acc, acc_sh;
   logic [DATA_W-1:0]        sat;

   assign stall    = out_valid && !out_ready;
   assign accept   = in_valid && in_ready;
   assign last_px  = accept && (r == RLAST) && (c == CLAST);
   assign last_out = out_valid && out_ready && (ocnt == OLAST);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         S_IDLE:  if (start)    nstate = S_RUN;
         S_RUN:   if (last_px)  nstate = S_DRAIN;
         S_DRAIN: if (last_out) nstate = S_FIN;
         S_FIN:                 nstate = S_IDLE;
         default:               nstate = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == S_RUN) && !stall;
      busy     = (state == S_RUN) || (state == S_DRAIN);
      done     = (state == S_FIN);
   end

   // Incoming column is rows r-2, r-1 and the pixel being accepted.
   always_comb begin
      col[0] = lb1[c];
      col[1] = lb0[c];
      col[2] = in_data;
      for (int i = 0; i < 3; i++) begin
         px[i*3+0] = win[i][0];
         px[i*3+1] = win[i][1];
         px[i*3+2] = col[i];
      end
      for (int n = 0; n < 9; n++)
         prod[n] = $signed({1'b0, px[n]}) * k[n];
   end

   always_ff @(posedge clk) begin
      if (state == S_IDLE && start)
         for (int n = 0; n < 9; n++)
            k[n] <= kernel[n*COEF_W +: COEF_W];
      if (accept) begin
         lb1[c] <= lb0[c];
         lb0[c] <= in_data;
         for (int i = 0; i < 3; i++) begin
            win[i][0] <= win[i][1];
            win[i][1] <= col[i];
         end
         prod_q <= prod;
      end
   end

   always_comb begin
      acc = RND;
      for (int n = 0; n < 9; n++)
         acc = acc + ACC_W'(prod_q[n]);
      acc_sh = acc >>> SHIFT;
      if (acc_sh[ACC_W-1])  sat = '0;
      else if (acc_sh > MAXV) sat = '1;
      else                  sat = acc_sh[DATA_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         c         <= '0;
         r         <= '0;
         ocnt      <= '0;
         v1        <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (state == S_IDLE && start) begin
            c    <= '0;
            r    <= '0;
            ocnt <= '0;
         end
         if (accept) begin
            c <= (c == CLAST) ? '0 : c + CW'(1);
            if (c == CLAST) r <= r + RW'(1);
         end
         if (!stall) begin
            v1        <= accept && (r >= RW'(2)) && (c >= CW'(2));
            out_valid <= v1;
            if (v1) out_data <= sat;
         end
         if (out_valid && out_ready) ocnt <= ocnt + OW'(1);
      end
   end

endmodule
